// File: rtl/trap_pkg.sv
// Shared constants and types for the trap/return sequencer.
package trap_pkg;

  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] UNIMP = 32'hc0001073;
  localparam logic [31:0] MRET  = 32'h30200073;

  localparam int unsigned CAUSE_ECALL_M = 11;
  localparam int unsigned CAUSE_ILLEGAL = 2;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned CSR_WE_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/trap_decode.sv
// Exact-match decode of the three trap-related instruction words.
module trap_decode
  import trap_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_ecall,
  output logic        is_unimp,
  output logic        is_mret
);

  assign is_ecall = (inst == ECALL);
  assign is_unimp = (inst == UNIMP);
  assign is_mret  = (inst == MRET);

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: CSR update, pipeline flush, then PC redirect.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [31:0]         ex_inst,
  input  logic [XLEN-1:0]     ex_pc,
  input  logic                stall_in,
  input  logic [XLEN-1:0]     mtvec_in,
  input  logic [XLEN-1:0]     mepc_in,
  input  logic [XLEN-1:0]     mstatus_in,
  output logic [CSR_WE_W-1:0] trap_csr_we,
  output logic [XLEN-1:0]     trap_mepc_out,
  output logic [XLEN-1:0]     trap_mcause_out,
  output logic [XLEN-1:0]     trap_mstatus_out,
  output logic                flush_out,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                busy
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

  logic is_ecall, is_unimp, is_mret;

  trap_decode u_decode (
    .inst     (ex_inst),
    .is_ecall (is_ecall),
    .is_unimp (is_unimp),
    .is_mret  (is_mret)
  );

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [XLEN-1:0]      target, target_nxt;
  logic [CSR_WE_W-1:0]  we_nxt;
  logic [XLEN-1:0]      mepc_nxt, mcause_nxt, mstatus_nxt, rpc_nxt;
  logic                 flush_nxt, rv_nxt, busy_nxt;
  logic [XLEN-1:0]      ms_trap, ms_ret;

  // mstatus images for trap entry and for mret
  always_comb begin
    ms_trap = mstatus_in;
    ms_trap[MSTATUS_MPIE] = mstatus_in[MSTATUS_MIE];
    ms_trap[MSTATUS_MIE]  = 1'b0;
    ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    ms_ret = mstatus_in;
    ms_ret[MSTATUS_MIE]  = mstatus_in[MSTATUS_MPIE];
    ms_ret[MSTATUS_MPIE] = 1'b1;
    ms_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    target_nxt  = target;
    we_nxt      = '0;
    mepc_nxt    = '0;
    mcause_nxt  = '0;
    mstatus_nxt = '0;
    case (state)
      IDLE: begin
        if (ex_valid && !stall_in && (is_ecall || is_unimp || is_mret)) begin
          state_nxt = FLUSH;
          cnt_nxt   = CW'(FLUSH_CYCLES - 1);
          if (is_mret) begin
            we_nxt      = 3'b100;
            mstatus_nxt = ms_ret;
            target_nxt  = mepc_in;
          end else begin
            we_nxt      = 3'b111;
            mepc_nxt    = ex_pc;
            mcause_nxt  = is_ecall ? XLEN'(CAUSE_ECALL_M) : XLEN'(CAUSE_ILLEGAL);
            mstatus_nxt = ms_trap;
            // direct mode only: mode bits are dropped
            target_nxt  = mtvec_in & ~XLEN'(3);
          end
        end
      end
      FLUSH: begin
        if (cnt == '0) state_nxt = REDIRECT;
        else           cnt_nxt   = cnt - CW'(1);
      end
      REDIRECT: begin
        if (!stall_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    flush_nxt = (state_nxt == FLUSH);
    rv_nxt    = (state_nxt == REDIRECT);
    rpc_nxt   = rv_nxt ? target_nxt : '0;
    busy_nxt  = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      target           <= '0;
      trap_csr_we      <= '0;
      trap_mepc_out    <= '0;
      trap_mcause_out  <= '0;
      trap_mstatus_out <= '0;
      flush_out        <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      busy             <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      target           <= target_nxt;
      trap_csr_we      <= we_nxt;
      trap_mepc_out    <= mepc_nxt;
      trap_mcause_out  <= mcause_nxt;
      trap_mstatus_out <= mstatus_nxt;
      flush_out        <= flush_nxt;
      redirect_valid   <= rv_nxt;
      redirect_pc      <= rpc_nxt;
      busy             <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic [31:0]     ex_inst;
  logic [XLEN-1:0] ex_pc;
  logic            stall_in;
  logic [XLEN-1:0] mtvec_in, mepc_in, mstatus_in;
  logic [2:0]      trap_csr_we;
  logic [XLEN-1:0] trap_mepc_out, trap_mcause_out, trap_mstatus_out;
  logic            flush_out, redirect_valid, busy;
  logic [XLEN-1:0] redirect_pc;

  int n_total = 0;
  int n_pass  = 0;

  trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .ex_inst          (ex_inst),
    .ex_pc            (ex_pc),
    .stall_in         (stall_in),
    .mtvec_in         (mtvec_in),
    .mepc_in          (mepc_in),
    .mstatus_in       (mstatus_in),
    .trap_csr_we      (trap_csr_we),
    .trap_mepc_out    (trap_mepc_out),
    .trap_mcause_out  (trap_mcause_out),
    .trap_mstatus_out (trap_mstatus_out),
    .flush_out        (flush_out),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control outputs plus CSR write mask; idle outputs are all zero.
  task automatic check_ctl(input string tag, input logic [2:0] we, input logic fl,
                           input logic rv, input logic [63:0] rpc, input logic bz);
    check({tag, ".we"},    64'(trap_csr_we), 64'(we));
    check({tag, ".flush"}, 64'(flush_out), 64'(fl));
    check({tag, ".rv"},    64'(redirect_valid), 64'(rv));
    check({tag, ".rpc"},   redirect_pc, rpc);
    check({tag, ".busy"},  64'(busy), 64'(bz));
  endtask

  // One full sequence: detect, two flush cycles, redirect (optionally stalled), back to idle.
  task automatic run_seq(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                         input logic [2:0] we, input logic [63:0] mepc, input logic [63:0] mcause,
                         input logic [63:0] ms, input logic [63:0] rpc,
                         input int n_stall, input bit hold);
    ex_valid = 1'b1; ex_inst = inst; ex_pc = pc;
    tick();
    check_ctl({tag, ".det"}, we, 1'b1, 1'b0, 64'h0, 1'b1);
    check({tag, ".mstatus"}, trap_mstatus_out, ms);
    if (we[0]) check({tag, ".mepc"}, trap_mepc_out, mepc);
    if (we[1]) check({tag, ".mcause"}, trap_mcause_out, mcause);
    if (!hold) ex_valid = 1'b0;
    tick();
    check_ctl({tag, ".fl2"}, 3'b000, 1'b1, 1'b0, 64'h0, 1'b1);
    stall_in = (n_stall > 0);
    tick();
    check_ctl({tag, ".rd"}, 3'b000, 1'b0, 1'b1, rpc, 1'b1);
    for (int i = 0; i < n_stall; i++) begin
      tick();
      check_ctl($sformatf("%s.hold%0d", tag, i), 3'b000, 1'b0, 1'b1, rpc, 1'b1);
    end
    stall_in = 1'b0;
    tick();
    check_ctl({tag, ".idle"}, 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_inst = '0; ex_pc = '0; stall_in = 1'b0;
    mtvec_in = 64'h2001; mepc_in = '0; mstatus_in = 64'h8;
    #12;
    check_ctl("rst", 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    rst = 1'b0;
    tick();
    check_ctl("post_rst", 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);

    run_seq("ecall", 32'h00000073, 64'h100, 3'b111, 64'h100, 64'd11, 64'h1880, 64'h2000, 0, 1'b0);

    mtvec_in = 64'h3003; mstatus_in = 64'h0;
    run_seq("unimp", 32'hc0001073, 64'h200, 3'b111, 64'h200, 64'd2, 64'h1800, 64'h3000, 0, 1'b0);

    mepc_in = 64'h104; mstatus_in = 64'h1880;
    run_seq("mret_stall", 32'h30200073, 64'h300, 3'b100, 64'h0, 64'h0, 64'h88, 64'h104, 3, 1'b0);

    // ecall held valid while busy: no extra writes, then accepted again right after redirect
    mtvec_in = 64'h2001; mstatus_in = 64'h8;
    run_seq("busy", 32'h00000073, 64'h400, 3'b111, 64'h400, 64'd11, 64'h1880, 64'h2000, 0, 1'b1);
    run_seq("b2b", 32'h00000073, 64'h404, 3'b111, 64'h404, 64'd11, 64'h1880, 64'h2000, 0, 1'b0);

    ex_valid = 1'b0; ex_inst = 32'h00000073;
    tick(); tick();
    check_ctl("novalid", 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    ex_valid = 1'b1; ex_inst = 32'h00000013;
    tick();
    check_ctl("nop", 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    ex_inst = 32'h00000073; stall_in = 1'b1;
    tick();
    check_ctl("stalled", 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    stall_in = 1'b0;

    // reset mid-flush aborts the sequence
    ex_pc = 64'h500;
    tick();
    check_ctl("pre_abort", 3'b111, 1'b1, 1'b0, 64'h0, 1'b1);
    ex_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check_ctl("abort", 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    check("abort.mstatus", trap_mstatus_out, 64'h0);
    rst = 1'b0;
    tick(); tick(); tick();
    check_ctl("after_abort", 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    run_seq("recover", 32'h00000073, 64'h600, 3'b111, 64'h600, 64'd11, 64'h1880, 64'h2000, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
